falafel_req_scheduler: RTL and testbench

Sequences the allocator core by popping requests from the alloc and free FIFOs and issuing them one at a time. The FIFOs are filled by the input arbiter. Contention between the two FIFOs is resolved with weighted round-robin that favours allocs, and only one operation is ever outstanding at the core. The block also provides a drain/pause control, per-class issue counters, and a completion watchdog.

---
 rtl/falafel_pkg.sv | 26 ++
 rtl/falafel_wrr_credit.sv | 45 ++++
 rtl/falafel_req_scheduler.sv | 138 +++++++++++++
 tb/tb_falafel_req_scheduler.sv | 500 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/falafel_pkg.sv
// Shared types and widths for the falafel allocator datapath.
// Holds the core request opcode, scheduler state encoding and size widening helper.
package falafel_pkg;

    localparam int DATA_W      = 32;
    localparam int MSG_ID_SIZE = 8;
    localparam int WORD_W      = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        OP_ALLOC = 1'b0,
        OP_FREE  = 1'b1
    } core_op_t;

    typedef enum logic [1:0] {
        SCHED_IDLE,
        SCHED_ISSUE,
        SCHED_WAIT
    } sched_state_t;

    function automatic logic [DATA_W-1:0] widen_size(input word_t size);
        return {{(DATA_W - WORD_W){1'b0}}, size};
    endfunction

endpackage

// File: rtl/falafel_wrr_credit.sv
// Weighted round-robin grant between alloc and free queues, favouring allocs.
// Grants are combinational (zero latency); the credit only moves on a granted cycle.
module falafel_wrr_credit #(
    parameter int unsigned ALLOC_WEIGHT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic alloc_pending,
    input  logic free_pending,
    input  logic enable,
    output logic grant_alloc,
    output logic grant_free
);

    localparam logic [7:0] WEIGHT = 8'(ALLOC_WEIGHT);

    logic [7:0] credit;
    logic       credit_left;

    assign credit_left = (credit != 8'd0);

    always_comb begin
        grant_alloc = 1'b0;
        grant_free  = 1'b0;
        if (enable) begin
            if (alloc_pending && (!free_pending || credit_left)) begin
                grant_alloc = 1'b1;
            end else if (free_pending) begin
                grant_free = 1'b1;
            end
        end
    end

    // Credit is only spent when an alloc wins against a waiting free.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit <= WEIGHT;
        end else if (grant_free) begin
            credit <= WEIGHT;
        end else if (grant_alloc && free_pending) begin
            credit <= credit - 8'd1;
        end
    end

endmodule

// File: rtl/falafel_req_scheduler.sv
// Pops alloc/free FIFOs and issues one request at a time to the allocator core.
// Pop is combinational in IDLE, val follows one cycle later and holds until rdy; nothing new issues until done or watchdog.
module falafel_req_scheduler
    import falafel_pkg::*;
#(
    parameter int unsigned ALLOC_WEIGHT = 4,
    parameter int unsigned WAIT_TIMEOUT = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   alloc_fifo_empty_i,
    output logic                   alloc_fifo_read_o,
    input  word_t                  alloc_fifo_dout_size_i,
    input  logic [MSG_ID_SIZE-1:0] alloc_fifo_dout_id_i,
    input  logic                   free_fifo_empty_i,
    output logic                   free_fifo_read_o,
    input  logic [DATA_W-1:0]      free_fifo_dout_i,
    output logic                   core_req_val_o,
    input  logic                   core_req_rdy_i,
    output core_op_t               core_req_op_o,
    output logic [DATA_W-1:0]      core_req_data_o,
    output logic [MSG_ID_SIZE-1:0] core_req_id_o,
    input  logic                   core_done_i,
    input  logic                   pause_i,
    output logic                   idle_o,
    output logic                   timeout_o,
    output logic [31:0]            alloc_issued_o,
    output logic [31:0]            free_issued_o
);

    localparam int unsigned CNT_W = (WAIT_TIMEOUT > 2) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_TIMEOUT - 1);

    sched_state_t     state;
    sched_state_t     next_state;
    logic             grant_en;
    logic             grant_alloc;
    logic             grant_free;
    logic             accept;
    logic             wait_expired;
    logic [CNT_W-1:0] wait_cnt;

    assign grant_en = (state == SCHED_IDLE) && !pause_i;

    falafel_wrr_credit #(
        .ALLOC_WEIGHT (ALLOC_WEIGHT)
    ) u_wrr (
        .clk           (clk_i),
        .rst           (rst_i),
        .alloc_pending (!alloc_fifo_empty_i),
        .free_pending  (!free_fifo_empty_i),
        .enable        (grant_en),
        .grant_alloc   (grant_alloc),
        .grant_free    (grant_free)
    );

    assign accept = (state == SCHED_ISSUE) && core_req_val_o && core_req_rdy_i;

    // A done in the final WAIT cycle wins over the watchdog.
    assign wait_expired = (state == SCHED_WAIT) && !core_done_i && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= SCHED_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            SCHED_IDLE: begin
                if (grant_alloc || grant_free) begin
                    next_state = SCHED_ISSUE;
                end
            end
            SCHED_ISSUE: begin
                if (accept) begin
                    next_state = SCHED_WAIT;
                end
            end
            SCHED_WAIT: begin
                if (core_done_i || wait_expired) begin
                    next_state = SCHED_IDLE;
                end
            end
            default: next_state = SCHED_IDLE;
        endcase
    end

    always_comb begin
        alloc_fifo_read_o = grant_alloc;
        free_fifo_read_o  = grant_free;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            core_req_val_o  <= 1'b0;
            core_req_op_o   <= OP_ALLOC;
            core_req_data_o <= '0;
            core_req_id_o   <= '0;
            idle_o          <= 1'b1;
            timeout_o       <= 1'b0;
            alloc_issued_o  <= '0;
            free_issued_o   <= '0;
            wait_cnt        <= '0;
        end else begin
            core_req_val_o <= (next_state == SCHED_ISSUE);
            idle_o         <= (next_state == SCHED_IDLE);
            timeout_o      <= timeout_o | wait_expired;

            if (grant_alloc) begin
                core_req_op_o   <= OP_ALLOC;
                core_req_data_o <= widen_size(alloc_fifo_dout_size_i);
                core_req_id_o   <= alloc_fifo_dout_id_i;
            end else if (grant_free) begin
                core_req_op_o   <= OP_FREE;
                core_req_data_o <= free_fifo_dout_i;
                core_req_id_o   <= '0;
            end

            if (accept && (core_req_op_o == OP_ALLOC)) begin
                alloc_issued_o <= alloc_issued_o + 32'd1;
            end
            if (accept && (core_req_op_o == OP_FREE)) begin
                free_issued_o <= free_issued_o + 32'd1;
            end

            if ((state == SCHED_WAIT) && (next_state == SCHED_WAIT)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_falafel_req_scheduler.sv
// Bench for falafel_req_scheduler: FIFO and core models around the DUT, scoreboarded requests.
module tb_falafel_req_scheduler;
    import falafel_pkg::*;

    localparam int unsigned W  = 4;
    localparam int unsigned TO = 8;

    logic                   clk = 1'b0;
    logic                   rst_i = 1'b1;
    logic                   alloc_fifo_empty_i = 1'b1;
    logic                   alloc_fifo_read_o;
    word_t                  alloc_fifo_dout_size_i = '0;
    logic [MSG_ID_SIZE-1:0] alloc_fifo_dout_id_i = '0;
    logic                   free_fifo_empty_i = 1'b1;
    logic                   free_fifo_read_o;
    logic [DATA_W-1:0]      free_fifo_dout_i = '0;
    logic                   core_req_val_o;
    logic                   core_req_rdy_i = 1'b1;
    core_op_t               core_req_op_o;
    logic [DATA_W-1:0]      core_req_data_o;
    logic [MSG_ID_SIZE-1:0] core_req_id_o;
    logic                   core_done_i = 1'b0;
    logic                   pause_i = 1'b0;
    logic                   idle_o;
    logic                   timeout_o;
    logic [31:0]            alloc_issued_o;
    logic [31:0]            free_issued_o;

    always #5 clk = ~clk;

    falafel_req_scheduler #(.ALLOC_WEIGHT(W), .WAIT_TIMEOUT(TO)) dut (
        .clk_i                  (clk),
        .rst_i                  (rst_i),
        .alloc_fifo_empty_i     (alloc_fifo_empty_i),
        .alloc_fifo_read_o      (alloc_fifo_read_o),
        .alloc_fifo_dout_size_i (alloc_fifo_dout_size_i),
        .alloc_fifo_dout_id_i   (alloc_fifo_dout_id_i),
        .free_fifo_empty_i      (free_fifo_empty_i),
        .free_fifo_read_o       (free_fifo_read_o),
        .free_fifo_dout_i       (free_fifo_dout_i),
        .core_req_val_o         (core_req_val_o),
        .core_req_rdy_i         (core_req_rdy_i),
        .core_req_op_o          (core_req_op_o),
        .core_req_data_o        (core_req_data_o),
        .core_req_id_o          (core_req_id_o),
        .core_done_i            (core_done_i),
        .pause_i                (pause_i),
        .idle_o                 (idle_o),
        .timeout_o              (timeout_o),
        .alloc_issued_o         (alloc_issued_o),
        .free_issued_o          (free_issued_o)
    );

    typedef struct packed {
        word_t                  size;
        logic [MSG_ID_SIZE-1:0] id;
    } aent_t;

    typedef struct packed {
        core_op_t               op;
        logic [DATA_W-1:0]      data;
        logic [MSG_ID_SIZE-1:0] id;
    } req_t;

    aent_t             aq[$];
    logic [DATA_W-1:0] fq[$];
    req_t              sb[$];

    int checks = 0;
    int errors = 0;
    bit done_en = 1'b1;
    int done_delay = 2;
    bit rd_a = 1'b0;
    bit rd_f = 1'b0;

    task automatic refresh_fifos();
        alloc_fifo_empty_i = (aq.size() == 0);
        free_fifo_empty_i  = (fq.size() == 0);
        if (aq.size() > 0) begin
            alloc_fifo_dout_size_i = aq[0].size;
            alloc_fifo_dout_id_i   = aq[0].id;
        end else begin
            alloc_fifo_dout_size_i = '0;
            alloc_fifo_dout_id_i   = '0;
        end
        free_fifo_dout_i = (fq.size() > 0) ? fq[0] : '0;
    endtask

    task automatic push_alloc(input word_t size, input logic [MSG_ID_SIZE-1:0] id, input bit expect_it);
        aent_t e;
        req_t  r;
        e.size = size;
        e.id   = id;
        aq.push_back(e);
        if (expect_it) begin
            r.op   = OP_ALLOC;
            r.data = {16'h0, size};
            r.id   = id;
            sb.push_back(r);
        end
        refresh_fifos();
    endtask

    task automatic push_free(input logic [DATA_W-1:0] addr, input bit expect_it);
        req_t r;
        fq.push_back(addr);
        if (expect_it) begin
            r.op   = OP_FREE;
            r.data = addr;
            r.id   = '0;
            sb.push_back(r);
        end
        refresh_fifos();
    endtask

    // FIFO model: read_o sampled mid-cycle, head popped just after the edge.
    always @(negedge clk) begin
        #3;
        rd_a = alloc_fifo_read_o;
        rd_f = free_fifo_read_o;
    end

    always @(posedge clk) begin
        #1;
        if (rd_a && aq.size() > 0) void'(aq.pop_front());
        if (rd_f && fq.size() > 0) void'(fq.pop_front());
        rd_a = 1'b0;
        rd_f = 1'b0;
        refresh_fifos();
    end

    // Core model: done pulse done_delay cycles after an accepted request.
    always begin
        @(negedge clk);
        #2;
        if (core_req_val_o && core_req_rdy_i && done_en) begin
            repeat (done_delay) @(negedge clk);
            core_done_i = 1'b1;
            @(negedge clk);
            core_done_i = 1'b0;
        end
    end

    // Scoreboard monitor and read-strobe invariants.
    always @(negedge clk) begin
        #2;
        if (!rst_i && core_req_val_o && core_req_rdy_i) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got op=%0d data=%h id=%h, none expected",
                         core_req_op_o, core_req_data_o, core_req_id_o);
            end else begin
                req_t e;
                e = sb.pop_front();
                if (core_req_op_o !== e.op || core_req_data_o !== e.data || core_req_id_o !== e.id) begin
                    errors++;
                    $display("FAIL sb_req: got op=%0d data=%h id=%h, want op=%0d data=%h id=%h",
                             core_req_op_o, core_req_data_o, core_req_id_o, e.op, e.data, e.id);
                end
            end
        end
        checks++;
        if ((alloc_fifo_read_o && free_fifo_read_o) || ((alloc_fifo_read_o || free_fifo_read_o) && !idle_o)) begin
            errors++;
            $display("FAIL read_strobe: alloc_rd=%0b free_rd=%0b idle=%0b", alloc_fifo_read_o, free_fifo_read_o, idle_o);
        end
    end

    task automatic wait_val(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (core_req_val_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_drained(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (idle_o && aq.size() == 0 && fq.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (core_req_val_o !== 1'b0 || alloc_fifo_read_o !== 1'b0 || free_fifo_read_o !== 1'b0 || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: val=%0b ard=%0b frd=%0b to=%0b, want all 0",
                     core_req_val_o, alloc_fifo_read_o, free_fifo_read_o, timeout_o);
        end
        checks++;
        if (core_req_op_o !== OP_ALLOC || core_req_data_o !== 32'h0 || core_req_id_o !== 8'h0) begin
            errors++;
            $display("FAIL reset_req: op=%0d data=%h id=%h, want 0/0/0", core_req_op_o, core_req_data_o, core_req_id_o);
        end
        checks++;
        if (alloc_issued_o !== 32'd0 || free_issued_o !== 32'd0 || idle_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_cnt: alloc=%0d free=%0d idle=%0b, want 0 0 1", alloc_issued_o, free_issued_o, idle_o);
        end
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    task automatic test_single_alloc();
        logic [31:0] a0;
        bit ok;
        @(negedge clk);
        a0 = alloc_issued_o;
        push_alloc(16'h40, 8'd3, 1'b1);
        #1;
        checks++;
        if (alloc_fifo_read_o !== 1'b1 || free_fifo_read_o !== 1'b0 || core_req_val_o !== 1'b0) begin
            errors++;
            $display("FAIL single_pop: ard=%0b frd=%0b val=%0b, want 1 0 0", alloc_fifo_read_o, free_fifo_read_o, core_req_val_o);
        end
        @(negedge clk);
        #1;
        checks++;
        if (alloc_fifo_read_o !== 1'b0 || core_req_val_o !== 1'b1 || core_req_op_o !== OP_ALLOC ||
            core_req_data_o !== 32'h40 || core_req_id_o !== 8'd3) begin
            errors++;
            $display("FAIL single_issue: ard=%0b val=%0b op=%0d data=%h id=%h, want 0 1 0 40 03",
                     alloc_fifo_read_o, core_req_val_o, core_req_op_o, core_req_data_o, core_req_id_o);
        end
        wait_drained(50, ok);
        checks++;
        if (!ok || alloc_issued_o !== a0 + 32'd1 || idle_o !== 1'b1) begin
            errors++;
            $display("FAIL single_done: drained=%0b alloc_issued=%0d idle=%0b, want 1 %0d 1", ok, alloc_issued_o, idle_o, a0 + 32'd1);
        end
    endtask

    task automatic test_wrr();
        logic [31:0] a0, f0;
        int credit, na, nf;
        bit ok;
        req_t r;
        @(negedge clk);
        a0 = alloc_issued_o;
        f0 = free_issued_o;
        for (int i = 0; i < 10; i++) begin
            push_alloc(word_t'(16'h100 + i), 8'(8'h20 + i), 1'b0);
            push_free(32'h1000 + 32'(i), 1'b0);
        end
        credit = W;
        na = 0;
        nf = 0;
        for (int g = 0; g < 20; g++) begin
            if (na < 10 && (nf == 10 || credit > 0)) begin
                if (nf < 10) credit--;
                r.op = OP_ALLOC;
                r.data = 32'h100 + 32'(na);
                r.id = 8'(8'h20 + na);
                na++;
            end else begin
                credit = W;
                r.op = OP_FREE;
                r.data = 32'h1000 + 32'(nf);
                r.id = '0;
                nf++;
            end
            sb.push_back(r);
        end
        wait_drained(400, ok);
        checks++;
        if (!ok || sb.size() != 0) begin
            errors++;
            $display("FAIL wrr_drain: drained=%0b left_expected=%0d, want 1 0", ok, sb.size());
        end
        checks++;
        if (alloc_issued_o !== a0 + 32'd10 || free_issued_o !== f0 + 32'd10) begin
            errors++;
            $display("FAIL wrr_counts: alloc=%0d free=%0d, want %0d %0d", alloc_issued_o, free_issued_o, a0 + 32'd10, f0 + 32'd10);
        end
    endtask

    task automatic test_rdy_stall();
        logic [31:0] f0;
        core_op_t op0;
        logic [DATA_W-1:0] d0;
        logic [MSG_ID_SIZE-1:0] i0;
        bit ok;
        @(negedge clk);
        core_req_rdy_i = 1'b0;
        f0 = free_issued_o;
        push_free(32'hBEEF, 1'b1);
        push_free(32'hCAFE, 1'b1);
        wait_val(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stall_val: val never rose, want 1");
        end
        op0 = core_req_op_o;
        d0 = core_req_data_o;
        i0 = core_req_id_o;
        checks++;
        if (op0 !== OP_FREE || d0 !== 32'hBEEF || i0 !== 8'h0) begin
            errors++;
            $display("FAIL stall_req: op=%0d data=%h id=%h, want 1 0000beef 00", op0, d0, i0);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (core_req_val_o !== 1'b1 || core_req_op_o !== op0 || core_req_data_o !== d0 || core_req_id_o !== i0 ||
                free_fifo_read_o !== 1'b0 || free_issued_o !== f0) begin
                errors++;
                $display("FAIL stall_hold: val=%0b data=%h frd=%0b free_issued=%0d, want 1 %h 0 %0d",
                         core_req_val_o, core_req_data_o, free_fifo_read_o, free_issued_o, d0, f0);
            end
        end
        @(negedge clk);
        core_req_rdy_i = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (free_issued_o !== f0 + 32'd1 || core_req_val_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_accept: free_issued=%0d val=%0b, want %0d 0", free_issued_o, core_req_val_o, f0 + 32'd1);
        end
        wait_drained(50, ok);
        checks++;
        if (!ok || free_issued_o !== f0 + 32'd2) begin
            errors++;
            $display("FAIL stall_drain: drained=%0b free_issued=%0d, want 1 %0d", ok, free_issued_o, f0 + 32'd2);
        end
    endtask

    task automatic test_pause();
        logic [31:0] a0;
        bit ok;
        @(negedge clk);
        done_delay = 4;
        a0 = alloc_issued_o;
        push_alloc(16'h11, 8'd5, 1'b1);
        wait_val(ok);
        @(negedge clk);
        #1;
        checks++;
        if (!ok || core_req_val_o !== 1'b0 || idle_o !== 1'b0) begin
            errors++;
            $display("FAIL pause_wait: seen_val=%0b val=%0b idle=%0b, want 1 0 0", ok, core_req_val_o, idle_o);
        end
        pause_i = 1'b1;
        push_alloc(16'h22, 8'd6, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (idle_o) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || alloc_issued_o !== a0 + 32'd1) begin
            errors++;
            $display("FAIL pause_complete: idle=%0b alloc_issued=%0d, want 1 %0d", ok, alloc_issued_o, a0 + 32'd1);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (alloc_fifo_read_o !== 1'b0 || idle_o !== 1'b1) begin
                errors++;
                $display("FAIL pause_hold: ard=%0b idle=%0b, want 0 1", alloc_fifo_read_o, idle_o);
            end
        end
        @(negedge clk);
        pause_i = 1'b0;
        #1;
        checks++;
        if (alloc_fifo_read_o !== 1'b1) begin
            errors++;
            $display("FAIL pause_release: ard=%0b, want 1", alloc_fifo_read_o);
        end
        wait_drained(50, ok);
        done_delay = 2;
        checks++;
        if (!ok || alloc_issued_o !== a0 + 32'd2) begin
            errors++;
            $display("FAIL pause_drain: drained=%0b alloc_issued=%0d, want 1 %0d", ok, alloc_issued_o, a0 + 32'd2);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] f0;
        bit ok;
        @(negedge clk);
        done_en = 1'b0;
        f0 = free_issued_o;
        push_free(32'h77, 1'b1);
        wait_val(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL timeout_val: val never rose, want 1");
        end
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            #1;
            if (k == 8) begin
                checks++;
                if (timeout_o !== 1'b0 || idle_o !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_early: to=%0b idle=%0b at cycle 7 of WAIT, want 0 0", timeout_o, idle_o);
                end
            end
            if (k == 9) begin
                checks++;
                if (timeout_o !== 1'b1 || idle_o !== 1'b1) begin
                    errors++;
                    $display("FAIL timeout_fire: to=%0b idle=%0b after 8 WAIT cycles, want 1 1", timeout_o, idle_o);
                end
            end
        end
        done_en = 1'b1;
        @(negedge clk);
        push_free(32'h99, 1'b1);
        wait_drained(50, ok);
        checks++;
        if (!ok || free_issued_o !== f0 + 32'd2 || timeout_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_after: drained=%0b free_issued=%0d to=%0b, want 1 %0d 1", ok, free_issued_o, timeout_o, f0 + 32'd2);
        end
    endtask

    task automatic test_reset_in_issue();
        bit ok;
        bit seen;
        @(negedge clk);
        core_req_rdy_i = 1'b0;
        push_free(32'h55, 1'b0);
        wait_val(ok);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (!ok || core_req_val_o !== 1'b0 || alloc_issued_o !== 32'd0 || free_issued_o !== 32'd0 ||
            idle_o !== 1'b1 || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_issue: seen_val=%0b val=%0b alloc=%0d free=%0d idle=%0b to=%0b, want 1 0 0 0 1 0",
                     ok, core_req_val_o, alloc_issued_o, free_issued_o, idle_o, timeout_o);
        end
        rst_i = 1'b0;
        core_req_rdy_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (core_req_val_o) seen = 1'b1;
        end
        checks++;
        if (seen || free_issued_o !== 32'd0) begin
            errors++;
            $display("FAIL rst_discard: reissued=%0b free_issued=%0d, want 0 0", seen, free_issued_o);
        end
    endtask

    initial begin
        refresh_fifos();
        test_reset();
        test_single_alloc();
        test_wrr();
        test_rdy_stall();
        test_pause();
        test_timeout();
        test_reset_in_issue();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected requests never issued, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
